// File: rtl/fp_addsub_pipe.sv
// Three-stage flush-to-zero floating-point add/subtract with round-to-nearest-even.
// Result valid 3 cycles after accept; each stage has its own valid, so a stalled output backs up stage by stage.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] x3,
    output logic [2:0]           exc
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;

    // handshake
    logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic s1_load, s2_load, s3_load, s2_ok, s3_ok;

    // stage 1 combinational
    logic             sa, sb, sb_eff, za, zb, nan_a, nan_b, inf_a, inf_b, b_big, big_sign;
    logic [EXP_W-1:0] ea, eb, big_exp, sml_exp, exp_diff;
    logic [MAN_W-1:0] ma, mb;
    logic [W-2:0]     mag_a, mag_b;
    logic [MAN_W:0]   big_sig, sml_sig;
    logic [SW-1:0]    sml_ext, sml_shift, lost_mask, sml_aligned;

    // stage 1 registers
    logic             s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_sign_q, s1_sign_d;
    logic             s1_sub_q, s1_sub_d, s1_zsign_q, s1_zsign_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [SW-1:0]    s1_big_q, s1_big_d, s1_sml_q, s1_sml_d;

    // stage 2 combinational
    logic [SW:0]      sum;
    logic [SW-1:0]    norm;
    logic [EXP_W+1:0] exp_n;
    logic             res_zero, res_uf;
    int               lz;

    // stage 2 registers
    logic             s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d, s2_zero_q, s2_zero_d;
    logic             s2_uf_q, s2_uf_d, s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [SW-1:0]    s2_norm_q, s2_norm_d;

    // stage 3 combinational and output registers
    logic             rnd_up, ovf;
    logic [MAN_W+1:0] man_r;
    logic [MAN_W-1:0] frac;
    logic [EXP_W:0]   exp_r;
    logic [W-1:0]     x3_q, x3_d;
    logic [2:0]       exc_q, exc_d;

    always_comb begin
        s3_ok    = !s3_vld_q || out_ready;
        s2_ok    = !s2_vld_q || s3_ok;
        in_ready = !s1_vld_q || s2_ok;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_vld_q && s2_ok;
        s3_load  = s2_vld_q && s3_ok;
        s1_vld_d = in_ready ? in_valid : s1_vld_q;
        s2_vld_d = s2_ok ? s1_vld_q : s2_vld_q;
        s3_vld_d = s3_ok ? s2_vld_q : s3_vld_q;
    end

    // S1: classify, order by magnitude, align the smaller operand with guard/round/sticky
    always_comb begin
        sa     = x1[W-1];
        ea     = x1[W-2:MAN_W];
        ma     = x1[MAN_W-1:0];
        sb     = x2[W-1];
        eb     = x2[W-2:MAN_W];
        mb     = x2[MAN_W-1:0];
        sb_eff = sb ^ op;
        za     = (ea == '0);
        zb     = (eb == '0);
        nan_a  = (&ea) && (|ma);
        nan_b  = (&eb) && (|mb);
        inf_a  = (&ea) && !(|ma);
        inf_b  = (&eb) && !(|mb);
        mag_a  = za ? '0 : {ea, ma};
        mag_b  = zb ? '0 : {eb, mb};
        b_big  = (mag_b > mag_a);
        if (b_big) begin
            big_exp  = eb;
            big_sig  = {1'b1, mb};
            big_sign = sb_eff;
            sml_exp  = ea;
            sml_sig  = za ? '0 : {1'b1, ma};
        end else begin
            big_exp  = ea;
            big_sig  = za ? '0 : {1'b1, ma};
            big_sign = sa;
            sml_exp  = eb;
            sml_sig  = zb ? '0 : {1'b1, mb};
        end
        exp_diff  = big_exp - sml_exp;
        sml_ext   = {sml_sig, 3'b000};
        sml_shift = sml_ext >> exp_diff;
        lost_mask = ~({SW{1'b1}} << exp_diff);
        if (32'(exp_diff) >= SW) begin
            sml_aligned = {{(SW-1){1'b0}}, |sml_sig};
        end else begin
            sml_aligned = {sml_shift[SW-1:1], sml_shift[0] | (|(sml_ext & lost_mask))};
        end

        s1_nan_d   = s1_nan_q;
        s1_inf_d   = s1_inf_q;
        s1_sign_d  = s1_sign_q;
        s1_sub_d   = s1_sub_q;
        s1_zsign_d = s1_zsign_q;
        s1_exp_d   = s1_exp_q;
        s1_big_d   = s1_big_q;
        s1_sml_d   = s1_sml_q;
        if (s1_load) begin
            s1_nan_d   = nan_a || nan_b || (inf_a && inf_b && (sa ^ sb_eff));
            s1_inf_d   = inf_a || inf_b;
            s1_sign_d  = inf_a ? sa : (inf_b ? sb_eff : big_sign);
            s1_sub_d   = sa ^ sb_eff;
            s1_zsign_d = za && zb && sa && sb_eff;
            s1_exp_d   = big_exp;
            s1_big_d   = {big_sig, 3'b000};
            s1_sml_d   = sml_aligned;
        end
    end

    // S2: magnitude add/subtract, then normalise so the leading one sits at bit SW-1
    always_comb begin
        if (s1_sub_q) begin
            sum = {1'b0, s1_big_q} - {1'b0, s1_sml_q};
        end else begin
            sum = {1'b0, s1_big_q} + {1'b0, s1_sml_q};
        end
        lz = 0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = SW - 1 - i;
        end
        if (sum[SW]) begin
            norm  = {sum[SW:2], sum[1] | sum[0]};
            exp_n = {2'b00, s1_exp_q} + (EXP_W+2)'(1);
        end else begin
            norm  = sum[SW-1:0] << lz;
            exp_n = {2'b00, s1_exp_q} - (EXP_W+2)'(lz);
        end
        res_zero = (sum == '0);
        // exp_n top bit is the sign of the borrowed exponent
        res_uf   = !res_zero && (exp_n[EXP_W+1] || (exp_n == '0));

        s2_nan_d  = s2_nan_q;
        s2_inf_d  = s2_inf_q;
        s2_zero_d = s2_zero_q;
        s2_uf_d   = s2_uf_q;
        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_norm_d = s2_norm_q;
        if (s2_load) begin
            s2_nan_d  = s1_nan_q;
            s2_inf_d  = s1_inf_q;
            s2_zero_d = res_zero || res_uf;
            s2_uf_d   = res_uf;
            s2_sign_d = (res_zero && !s1_inf_q) ? s1_zsign_q : s1_sign_q;
            s2_exp_d  = exp_n[EXP_W-1:0];
            s2_norm_d = norm;
        end
    end

    // S3: round to nearest even, detect overflow, pack with special-case priority
    always_comb begin
        rnd_up = s2_norm_q[2] && (s2_norm_q[1] || s2_norm_q[0] || s2_norm_q[3]);
        man_r  = {1'b0, s2_norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        frac   = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
        exp_r  = {1'b0, s2_exp_q} + {{EXP_W{1'b0}}, man_r[MAN_W+1]};
        ovf    = (exp_r >= {1'b0, {EXP_W{1'b1}}});

        x3_d  = x3_q;
        exc_d = exc_q;
        if (s3_load) begin
            if (s2_nan_q) begin
                x3_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                exc_d = 3'b100;
            end else if (s2_inf_q) begin
                x3_d  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                exc_d = 3'b000;
            end else if (s2_zero_q) begin
                x3_d  = {s2_sign_q, {(W-1){1'b0}}};
                exc_d = {2'b00, s2_uf_q};
            end else if (ovf) begin
                x3_d  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                exc_d = 3'b010;
            end else begin
                x3_d  = {s2_sign_q, exp_r[EXP_W-1:0], frac};
                exc_d = 3'b000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_zsign_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_big_q   <= '0;
            s1_sml_q   <= '0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_uf_q    <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_norm_q  <= '0;
            x3_q       <= '0;
            exc_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s3_vld_q   <= s3_vld_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_zsign_q <= s1_zsign_d;
            s1_exp_q   <= s1_exp_d;
            s1_big_q   <= s1_big_d;
            s1_sml_q   <= s1_sml_d;
            s2_nan_q   <= s2_nan_d;
            s2_inf_q   <= s2_inf_d;
            s2_zero_q  <= s2_zero_d;
            s2_uf_q    <= s2_uf_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_norm_q  <= s2_norm_d;
            x3_q       <= x3_d;
            exc_q      <= exc_d;
        end
    end

    assign out_valid = s3_vld_q;
    assign x3        = x3_q;
    assign exc       = exc_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision vectors with hand-computed results.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1, x2, x3;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  exc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x1       (x1),
        .x2       (x2),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x3       (x3),
        .exc      (exc)
    );

    // Drives one op into an empty pipeline (called at posedge+1, out_ready high) and
    // returns the result plus the number of rising edges, accept edge included, until out_valid.
    task automatic send_and_wait(input logic [31:0] a, input logic [31:0] b, input logic o,
                                 output logic [31:0] r, output logic [2:0] e, output int lat);
        x1 = a; x2 = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = x3;
        e = exc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0; op = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (x3 !== 32'h0) $display("FAIL reset x3: got %h want 00000000", x3); else n_pass++;
        n_total++; if (exc !== 3'b000) $display("FAIL reset exc: got %b want 000", exc); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic_add;
        logic [31:0] r; logic [2:0] e; int lat;
        send_and_wait(32'h3F800000, 32'h40000000, 1'b0, r, e, lat);
        n_total++; if (lat !== 3) $display("FAIL add latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (r !== 32'h40400000) $display("FAIL add x3: got %h want 40400000", r); else n_pass++;
        n_total++; if (e !== 3'b000) $display("FAIL add exc: got %b want 000", e); else n_pass++;
    endtask

    task automatic test_cancel;
        logic [31:0] va[4], vb[4], vr[4];
        logic        vo[4];
        logic [31:0] r; logic [2:0] e; int lat;
        va = '{32'h40490FDB, 32'hBF800000, 32'h80000000, 32'h80000000};
        vb = '{32'h40490FDB, 32'h3F800000, 32'h80000000, 32'h00000000};
        vo = '{1'b1, 1'b0, 1'b0, 1'b1};
        vr = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            send_and_wait(va[i], vb[i], vo[i], r, e, lat);
            n_total++; if (r !== vr[i]) $display("FAIL cancel[%0d] x3: got %h want %h", i, r, vr[i]); else n_pass++;
            n_total++; if (e !== 3'b000) $display("FAIL cancel[%0d] exc: got %b want 000", i, e); else n_pass++;
        end
    endtask

    task automatic test_rounding;
        logic [31:0] vb[2], vr[2];
        logic [31:0] r; logic [2:0] e; int lat;
        vb = '{32'h33800000, 32'h33800001};
        vr = '{32'h3F800000, 32'h3F800001};
        for (int i = 0; i < 2; i++) begin
            send_and_wait(32'h3F800000, vb[i], 1'b0, r, e, lat);
            n_total++; if (r !== vr[i]) $display("FAIL round[%0d] x3: got %h want %h", i, r, vr[i]); else n_pass++;
            n_total++; if (e !== 3'b000) $display("FAIL round[%0d] exc: got %b want 000", i, e); else n_pass++;
        end
    endtask

    task automatic test_specials;
        logic [31:0] va[5], vb[5], vr[5];
        logic        vo[5];
        logic [2:0]  ve[5];
        logic [31:0] r; logic [2:0] e; int lat;
        va = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h00800000, 32'h7FC00001};
        vb = '{32'hFF800000, 32'h7F7FFFFF, 32'h40000000, 32'h00800001, 32'h3F800000};
        vo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vr = '{32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h80000000, 32'h7FC00000};
        ve = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b100};
        for (int i = 0; i < 5; i++) begin
            send_and_wait(va[i], vb[i], vo[i], r, e, lat);
            n_total++; if (r !== vr[i]) $display("FAIL special[%0d] x3: got %h want %h", i, r, vr[i]); else n_pass++;
            n_total++; if (e !== ve[i]) $display("FAIL special[%0d] exc: got %b want %b", i, e, ve[i]); else n_pass++;
        end
    endtask

    task test_backpressure;
        logic [31:0] va[6], vb[6], vr[6], got[6], held;
        logic        vo[6];
        bit          saw_stall, stable, tmo;
        int          acc_before_stall;
        va = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000};
        vb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40800000, 32'h3F000000};
        vo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vr = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000, 32'h41000000, 32'h3F800000};
        saw_stall = 1'b0; stable = 1'b1; tmo = 1'b0; acc_before_stall = 0;
        out_ready = 1'b0;
        fork
            begin : producer
                for (int i = 0; i < 6; i++) begin
                    logic acc;
                    int   guard;
                    x1 = va[i]; x2 = vb[i]; op = vo[i]; in_valid = 1'b1;
                    acc = 1'b0; guard = 0;
                    while (!acc && guard < 60) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!in_ready) saw_stall = 1'b1;
                        else if (!saw_stall) acc_before_stall++;
                        @(posedge clk); #1;
                        guard++;
                    end
                    if (!acc) tmo = 1'b1;
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int g;
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 60) begin @(negedge clk); g++; end
                if (!out_valid) tmo = 1'b1;
                held = x3;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    if (x3 !== held || out_valid !== 1'b1) stable = 1'b0;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int j = 0; j < 6; j++) begin
                    g = 0;
                    @(negedge clk);
                    while (!out_valid && g < 60) begin @(negedge clk); g++; end
                    if (!out_valid) tmo = 1'b1;
                    got[j] = x3;
                end
            end
        join
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            n_total++; if (got[k] !== vr[k]) $display("FAIL bp_order[%0d] x3: got %h want %h", k, got[k], vr[k]); else n_pass++;
        end
        n_total++; if (stable !== 1'b1) $display("FAIL bp_hold: x3/out_valid changed while stalled (held %h)", held); else n_pass++;
        n_total++; if (saw_stall !== 1'b1) $display("FAIL bp_in_ready: got never-low want low during stall"); else n_pass++;
        n_total++; if (acc_before_stall !== 3) $display("FAIL bp_depth: got %0d accepts before stall want 3", acc_before_stall); else n_pass++;
        n_total++; if (tmo !== 1'b0) $display("FAIL bp_timeout: got handshake timeout want none"); else n_pass++;
    endtask

    task automatic test_reset_midflight;
        logic [31:0] r; logic [2:0] e; int lat;
        bit leak;
        out_ready = 1'b1;
        x1 = 32'h3F800000; x2 = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        x1 = 32'h40000000; x2 = 32'h40000000;
        @(posedge clk); #1;
        x1 = 32'h3F800000; x2 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL rst_mid pre out_valid: got %b want 1", out_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (x3 !== 32'h0) $display("FAIL rst_mid x3: got %h want 00000000", x3); else n_pass++;
        n_total++; if (exc !== 3'b000) $display("FAIL rst_mid exc: got %b want 000", exc); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mid in_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) leak = 1'b1;
        end
        n_total++; if (leak !== 1'b0) $display("FAIL rst_mid stale: got out_valid after release want none"); else n_pass++;
        @(posedge clk); #1;
        send_and_wait(32'h40000000, 32'h40000000, 1'b0, r, e, lat);
        n_total++; if (lat !== 3) $display("FAIL rst_mid latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (r !== 32'h40800000) $display("FAIL rst_mid x3: got %h want 40800000", r); else n_pass++;
        n_total++; if (e !== 3'b000) $display("FAIL rst_mid exc_after: got %b want 000", e); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic_add;
        test_cancel;
        test_rounding;
        test_specials;
        test_backpressure;
        test_reset_midflight;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
